pkt_ram_trailer: RTL
====================

Name: pkt_ram_trailer

Overview:
Store-and-forward packet buffer on block RAM. It accepts one packet of DATA_WIDTH words over a valid/ready/last stream and appends TRAILER_LEN generated trailer words. It then replays the whole frame, payload followed by trailer, on a valid/ready/last output stream with backpressure. It is the parametrised successor of the fixed 8-bit, 24-word, 4-word-trailer receive/append/transmit RAM, and sits between the byte receiver and the downstream transmitter.

Parameters:
- DATA_WIDTH, 8: word width in bits (≥1).
- DEPTH, 24: RAM words; total frame capacity including trailer (≥ TRAILER_LEN+1).
- TRAILER_LEN, 4: trailer words appended per packet (0 allowed: no trailer).
- TRAILER_BASE, 1: value of the first trailer word.
- TRAILER_STEP, 1: increment between successive trailer words, modulo 2^DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_data  in  DATA_WIDTH  input word.
- s_valid  in  1  input word valid.
- s_last  in  1  marks final payload word; qualified by s_valid.
- s_ready  out  1  block can accept an input word.
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  output word valid.
- m_last  out  1  final word of the frame.
- m_ready  in  1  downstream accepts the output word.
- pkt_len  out  $clog2(DEPTH+1)  total frame length (payload + trailer); valid in SEND.
- truncated  out  1  current frame was cut at MAX_PAYLOAD.

Behaviour:
- Reset values: rst high at any time forces state RECV, all address/count registers 0, s_ready=0 during reset, m_valid=0, m_last=0, m_data=0, pkt_len=0, truncated=0. RAM contents are undefined and not cleared. Reset mid-packet abandons the frame with no partial output.
- MAX_PAYLOAD = DEPTH − TRAILER_LEN.
- Input transfer: s_valid & s_ready on a rising edge. Output transfer: m_valid & m_ready on a rising edge.
- State RECV:
  - s_ready=1 and m_valid=0.
  - Each transfer writes s_data to mem[wr_addr], then wr_addr+1.
  - A transfer with s_last=1 ends the payload.
  - A transfer that fills word MAX_PAYLOAD without s_last also ends the payload: it is a forced last, truncated is set to 1, and further input is refused (s_ready=0). The sender's remaining words are not consumed by this block; dropping them is upstream's job.
  - On payload end, go to TRAILER, or straight to SEND if TRAILER_LEN=0.
  - The first transfer of a new packet clears truncated.
- State TRAILER:
  - s_ready=0.
  - One trailer word is written per cycle: word i (0..TRAILER_LEN−1) = TRAILER_BASE + i·TRAILER_STEP, truncated to DATA_WIDTH, at address payload_len+i.
  - After TRAILER_LEN cycles, pkt_len = payload_len + TRAILER_LEN and the state goes to SEND.
- State SEND:
  - s_ready=0.
  - Words are read from address 0 up to pkt_len−1 in order. The RAM read is registered (1-cycle latency).
  - m_valid rises no later than 2 cycles after entering SEND.
  - m_data, m_valid and m_last are held stable while m_valid & !m_ready.
  - With m_ready held high, the block sustains one word per cycle; no bubbles are allowed after the first word (prefetch/skid as needed).
  - m_last=1 only on word pkt_len−1.
  - On the transfer of the m_last word: m_valid=0 next cycle, addresses clear, state returns to RECV, and s_ready=1 next cycle.
- Width rules: addresses are $clog2(DEPTH) bits and never wrap; the truncation limit prevents overflow. pkt_len never exceeds DEPTH.
- Simultaneous events:
  - s_valid is ignored outside RECV.
  - m_ready is ignored outside SEND.
  - A single-word packet (s_last on the first word) is legal: pkt_len = 1 + TRAILER_LEN.

Test Plan:
1. Defaults; send 10,20,30 with s_last on 30; m_ready=1 → output 10,20,30,1,2,3,4, m_last on 4, pkt_len=7, truncated=0, no gaps between output words.
2. Defaults; send 25 words 1..25 with no s_last → s_ready drops after word 20; output 1..20,1,2,3,4 (24 words), m_last on 24th, truncated=1.
3. Scenario 1 with m_ready toggling 1,0,0,1,… → every word appears exactly once in order; m_data stable during stalls; m_last only on 4.
4. Two back-to-back packets (5,6 then 7,8,9,s_last) → frames 5,6,1,2,3,4 then 7,8,9,1,2,3,4; the second packet is accepted only after the first frame's m_last transfer.
5. Assert rst mid-SEND after 2 output words, then release and send 42 → m_valid=0 immediately on rst; the next frame is 42,1,2,3,4 only.
6. TRAILER_LEN=0, DATA_WIDTH=16, DEPTH=4; send 0xABCD,0x1234 with s_last → output 0xABCD,0x1234, pkt_len=2. Separately, TRAILER_BASE=254, TRAILER_STEP=1, default widths → trailer 254,255,0,1.

Source files
------------

// File: rtl/pkt_ram_trailer.sv
// Store-and-forward packet buffer: captures one payload into block RAM, appends
// generated trailer words, then replays the whole frame on a backpressured stream.
module pkt_ram_trailer #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 24,
   parameter int TRAILER_LEN  = 4,
   parameter int TRAILER_BASE = 1,
   parameter int TRAILER_STEP = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         s_valid,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_valid,
   output logic                         m_last,
   input  logic                         m_ready,
   output logic [$clog2(DEPTH+1)-1:0]   pkt_len,
   output logic                         truncated
);

   localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW          = $clog2(DEPTH + 1);
   localparam int TW          = (TRAILER_LEN > 1) ? $clog2(TRAILER_LEN) : 1;
   localparam int MAX_PAYLOAD = DEPTH - TRAILER_LEN;

   typedef enum logic [1:0] {RECV, TRAILER, SEND} state_t;

   state_t                state, state_nxt;
   logic [AW-1:0]         wr_addr;
   logic [TW-1:0]         tr_idx;
   logic [DATA_WIDTH-1:0] tr_word;
   logic [LW-1:0]         rd_cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  rd_pend, rd_pend_last;
   logic [DATA_WIDTH-1:0] sk_data;
   logic                  sk_valid, sk_last;

   logic                  in_xfer, out_xfer, wr_at_max, forced_last, payload_end;
   logic                  tr_done, frame_done, issue, is_last_rd, we;
   logic [LW-1:0]         wr_len;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] wdata;

   assign s_ready     = (state == RECV) & ~rst;
   assign in_xfer     = s_valid & s_ready;
   assign out_xfer    = m_valid & m_ready;
   assign wr_at_max   = (wr_addr == AW'(MAX_PAYLOAD - 1));
   assign forced_last = in_xfer & ~s_last & wr_at_max;
   assign payload_end = in_xfer & (s_last | wr_at_max);
   assign tr_done     = (state == TRAILER) & (tr_idx == TW'(TRAILER_LEN - 1));
   assign frame_done  = out_xfer & m_last;
   assign wr_len      = LW'(wr_addr) + LW'(1);

   // Words held downstream of the RAM (output reg, skid reg, read in flight)
   // after this cycle's output transfer; a new read may issue only if one slot is free.
   assign occ         = 2'(m_valid) + 2'(sk_valid) + 2'(rd_pend) - 2'(out_xfer);
   assign issue       = (state == SEND) && (rd_cnt < pkt_len) && (occ <= 2'd1);
   assign is_last_rd  = (rd_cnt == pkt_len - LW'(1));

   assign we          = in_xfer | (state == TRAILER);
   assign wdata       = (state == TRAILER) ? tr_word : s_data;

   always_comb begin
      state_nxt = state;
      unique case (state)
         RECV:    if (payload_end) state_nxt = (TRAILER_LEN == 0) ? SEND : TRAILER;
         TRAILER: if (tr_done)     state_nxt = SEND;
         SEND:    if (frame_done)  state_nxt = RECV;
         default:                  state_nxt = RECV;
      endcase
   end

   // NOTE: every clocked register uses non-blocking assignment so all flops
   // update together from pre-edge values regardless of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RECV;
      else     state <= state_nxt;
   end

   // NOTE: the RAM has no reset so it maps onto block RAM; its contents are
   // only ever read back after being written for the current frame.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wdata;
      rd_q <= mem[rd_cnt[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr      <= '0;
         tr_idx       <= '0;
         tr_word      <= '0;
         pkt_len      <= '0;
         truncated    <= 1'b0;
         rd_cnt       <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         sk_data      <= '0;
         sk_valid     <= 1'b0;
         sk_last      <= 1'b0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         m_last       <= 1'b0;
      end else begin
         case (state)
            RECV: begin
               if (in_xfer) begin
                  truncated <= forced_last | (truncated & (wr_addr != '0));
                  if (payload_end) begin
                     tr_word <= DATA_WIDTH'(TRAILER_BASE);
                     tr_idx  <= '0;
                     if (TRAILER_LEN == 0) begin
                        wr_addr <= '0;
                        pkt_len <= wr_len;
                     end else begin
                        wr_addr <= wr_addr + AW'(1);
                     end
                  end else begin
                     wr_addr <= wr_addr + AW'(1);
                  end
               end
            end
            TRAILER: begin
               tr_word <= tr_word + DATA_WIDTH'(TRAILER_STEP);
               tr_idx  <= tr_idx + TW'(1);
               if (tr_done) begin
                  wr_addr <= '0;
                  pkt_len <= wr_len;
               end else begin
                  wr_addr <= wr_addr + AW'(1);
               end
            end
            default: ;
         endcase

         if (frame_done)  rd_cnt <= '0;
         else if (issue)  rd_cnt <= rd_cnt + LW'(1);
         rd_pend      <= issue;
         rd_pend_last <= issue & is_last_rd;

         // Output register refills from the skid first, then from the RAM read;
         // a read landing while the output is stalled parks in the skid.
         if (out_xfer || !m_valid) begin
            if (sk_valid) begin
               m_data   <= sk_data;
               m_valid  <= 1'b1;
               m_last   <= sk_last;
               sk_valid <= rd_pend;
               sk_last  <= rd_pend_last;
               if (rd_pend) sk_data <= rd_q;
            end else begin
               m_valid <= rd_pend;
               m_last  <= rd_pend_last;
               if (rd_pend) m_data <= rd_q;
            end
         end else if (rd_pend) begin
            sk_data  <= rd_q;
            sk_valid <= 1'b1;
            sk_last  <= rd_pend_last;
         end
      end
   end

endmodule
